// File: rtl/aes_pkg.sv
// Shared AES SubBytes definitions: forward/inverse S-box tables, engine FSM states, byte-select helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Bit offset of byte idx inside an nbytes-wide bus; byte 0 is the MSB byte.
    function automatic int byte_lsb(input int nbytes, input int idx);
        return 8 * (nbytes - 1 - idx);
    endfunction

endpackage

// File: rtl/aes_sub_bytes_engine_if.sv
// Block-level handshake bundle for the SubBytes engine: input block, output block, status.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the input and output side; master = upstream/downstream side, slave = engine.
interface aes_sub_bytes_engine_if #(
    parameter int STATE_BYTES = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [8*STATE_BYTES-1:0] in_state;
    logic                     in_inverse;
    logic                     out_valid;
    logic                     out_ready;
    logic [8*STATE_BYTES-1:0] out_state;
    logic                     out_inverse;
    logic                     busy;

    modport master (
        output in_valid, in_state, in_inverse, out_ready,
        input  in_ready, out_valid, out_state, out_inverse, busy
    );

    modport slave (
        input  in_valid, in_state, in_inverse, out_ready,
        output in_ready, out_valid, out_state, out_inverse, busy
    );
endinterface

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane: forward or inverse substitution of a single byte.
// Latency: 0 cycles (pure table lookup).
// Backpressure: none. Ports: byte_in (byte to substitute), inverse (1 = InvS), byte_out (result).
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] byte_in,
    input  logic       inverse,
    output logic [7:0] byte_out
);
    assign byte_out = inverse ? INV_SBOX[byte_in] : SBOX[byte_in];
endmodule

// File: rtl/aes_sub_bytes_engine.sv
// Multi-cycle SubBytes/InvSubBytes over a whole AES state, LANES bytes substituted per cycle.
// Latency: block accepted at edge E0 is presented (out_valid) after edge E0+BEATS; one DONE cycle per block.
// Backpressure: result held stable in DONE until out_ready; in_ready = IDLE | (DONE & out_ready).
// Ports: clk, rst (async active-high), io (slave side of aes_sub_bytes_engine_if: in_*, out_*, busy).
module aes_sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int STATE_BYTES = 16,
    parameter int LANES       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_sub_bytes_engine_if.slave io
);
    localparam int               BEATS    = STATE_BYTES / LANES;
    localparam int               CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    generate
        if ((LANES != 1) && (LANES != 2) && (LANES != 4) && (LANES != 8) && (LANES != 16)) begin : g_bad_lanes
            $error("aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
        if ((STATE_BYTES % LANES) != 0) begin : g_bad_split
            $error("aes_sub_bytes_engine: STATE_BYTES must be a multiple of LANES");
        end
    endgenerate

    fsm_t                     r_fsm;
    fsm_t                     w_fsm_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [8*STATE_BYTES-1:0] r_state;
    logic                     r_inverse;
    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_last;
    logic [7:0]               w_lane_in  [LANES];
    logic [7:0]               w_lane_out [LANES];

    assign w_last   = (r_cnt == LAST_CNT);
    assign w_accept = io.in_valid & w_in_ready;

    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_in_ready = 1'b0;
        case (r_fsm)
            IDLE: begin
                w_in_ready = 1'b1;
                if (io.in_valid) begin
                    w_fsm_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_fsm_nxt = DONE;
                end
            end
            DONE: begin
                // Draining the result frees the state register for a new block in the same cycle.
                w_in_ready = io.out_ready;
                if (io.out_ready) begin
                    w_fsm_nxt = io.in_valid ? RUN : IDLE;
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // Lane l works on byte cnt*LANES + l of the state register.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_in[l] = r_state[byte_lsb(STATE_BYTES, int'(r_cnt) * LANES + l) +: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox_lane u_lane (
            .byte_in  (w_lane_in[g]),
            .inverse  (r_inverse),
            .byte_out (w_lane_out[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm     <= IDLE;
            r_cnt     <= '0;
            r_state   <= '0;
            r_inverse <= 1'b0;
        end else begin
            r_fsm <= w_fsm_nxt;
            if (w_accept) begin
                r_state   <= io.in_state;
                r_inverse <= io.in_inverse;
                r_cnt     <= '0;
            end else if (r_fsm == RUN) begin
                for (int l = 0; l < LANES; l++) begin
                    r_state[byte_lsb(STATE_BYTES, int'(r_cnt) * LANES + l) +: 8] <= w_lane_out[l];
                end
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign io.in_ready    = w_in_ready;
    assign io.out_valid   = (r_fsm == DONE);
    assign io.out_state   = r_state;
    assign io.out_inverse = r_inverse;
    assign io.busy        = (r_fsm == RUN) || (r_fsm == DONE);

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// Bench for aes_sub_bytes_engine at LANES = 4, 1 and 16, run side by side with independent stimulus.
// Reference S-boxes are derived from GF(2^8) inversion plus the AES affine map.
// A scoreboard queue per instance is filled at acceptance and drained by one monitor.
module tb_aes_sub_bytes_engine;
    localparam int SB = 16;
    localparam int NI = 3;
    localparam int W  = 8 * SB;

    typedef struct packed {
        logic [W-1:0] st;
        logic         inv;
        int unsigned  acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_a [NI];
    logic         iv    [NI];
    logic [W-1:0] ist   [NI];
    logic         iinv  [NI];
    logic         ordy  [NI];
    logic         ir    [NI];
    logic         ov    [NI];
    logic [W-1:0] ost   [NI];
    logic         oinv  [NI];
    logic         bsy   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        aes_sub_bytes_engine_if #(.STATE_BYTES(SB)) u_if ();
        assign u_if.in_valid   = iv[g];
        assign u_if.in_state   = ist[g];
        assign u_if.in_inverse = iinv[g];
        assign u_if.out_ready  = ordy[g];
        assign ir[g]   = u_if.in_ready;
        assign ov[g]   = u_if.out_valid;
        assign ost[g]  = u_if.out_state;
        assign oinv[g] = u_if.out_inverse;
        assign bsy[g]  = u_if.busy;
        aes_sub_bytes_engine #(.STATE_BYTES(SB), .LANES(L)) u_dut (
            .clk (clk),
            .rst (rst_a[g]),
            .io  (u_if)
        );
    end

    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_done  = 0;
    exp_t         q [NI][$];
    bit           seen     [NI];
    bit           held     [NI];
    logic [W-1:0] prev_st  [NI];
    logic         prev_inv [NI];
    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];

    function automatic int lanes_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
    endfunction

    function automatic int beats_of(input int k);
        return SB / lanes_of(k);
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, x);   // x^254 = x^-1, and 0 -> 0
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [W-1:0] sub_block(input logic [W-1:0] s, input logic inv);
        logic [W-1:0] o;
        logic [7:0]   b;
        o = '0;
        for (int i = 0; i < SB; i++) begin
            b = s[8*(SB-1-i) +: 8];
            o[8*(SB-1-i) +: 8] = inv ? isb[b] : sb[b];
        end
        return o;
    endfunction

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic chk(input int k, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL L%0d %s: got %h, expected %h", lanes_of(k), name, act, exp);
        end
    endtask

    task automatic chki(input int k, input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL L%0d %s: got %0d, expected %0d", lanes_of(k), name, act, exp);
        end
    endtask

    task automatic fail_now(input int k, input string name);
        n_tests++;
        n_fail++;
        $display("FAIL L%0d %s", lanes_of(k), name);
    endtask

    // ---------------- monitor ----------------
    task automatic mon_step(input int k);
        exp_t e;
        if (held[k]) begin
            chki(k, "hold_valid", int'(ov[k]), 1);
            chk (k, "hold_state", ost[k], prev_st[k]);
            chki(k, "hold_inverse", int'(oinv[k]), int'(prev_inv[k]));
            if (!ordy[k]) chki(k, "hold_in_ready", int'(ir[k]), 0);
            held[k] = 1'b0;
        end
        if (ov[k]) begin
            if (q[k].size() == 0) begin
                fail_now(k, "spurious_out_valid");
            end else begin
                e = q[k][0];
                if (!seen[k]) begin
                    chki(k, "latency", int'(cyc - e.acc), beats_of(k));
                    seen[k] = 1'b1;
                end
                if (ordy[k]) begin
                    void'(q[k].pop_front());
                    chk (k, "out_state", ost[k], e.st);
                    chki(k, "out_inverse", int'(oinv[k]), int'(e.inv));
                    seen[k] = 1'b0;
                end else begin
                    held[k]     = 1'b1;
                    prev_st[k]  = ost[k];
                    prev_inv[k] = oinv[k];
                end
            end
        end
    endtask

    // ---------------- stimulus (called at posedge+1) ----------------
    task automatic send(input int k, input logic [W-1:0] st, input logic inv,
                        input logic [W-1:0] exp_st, output int unsigned acc);
        exp_t e;
        bit   ok;
        ok  = 1'b0;
        acc = 0;
        iv[k] = 1'b1; ist[k] = st; iinv[k] = inv;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ir[k]) begin
                acc   = cyc + 1;
                e.st  = exp_st; e.inv = inv; e.acc = acc;
                q[k].push_back(e);
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) fail_now(k, "accept_timeout");
        else begin
            @(posedge clk); #1;
        end
        // Disturb the inputs while the block is being processed.
        iv[k] = 1'b0; ist[k] = rnd(); iinv[k] = ~inv;
    endtask

    task automatic send_m(input int k, input logic [W-1:0] st, input logic inv, output int unsigned acc);
        send(k, st, inv, sub_block(st, inv), acc);
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        while (q[k].size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q[k].size() != 0) fail_now(k, "drain_timeout");
        @(posedge clk); #1;
    endtask

    task automatic run_inst(input int k);
        int unsigned  a0, a1, a2, dummy;
        logic [W-1:0] r, r0, r1, r2, blk;
        int           t;

        rst_a[k] = 1'b1; iv[k] = 1'b0; ist[k] = '0; iinv[k] = 1'b0; ordy[k] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chki(k, "in_reset_out_valid", int'(ov[k]), 0);
        chki(k, "in_reset_busy", int'(bsy[k]), 0);
        @(posedge clk); #1;
        rst_a[k] = 1'b0;
        @(negedge clk);
        chki(k, "rst_in_ready", int'(ir[k]), 1);
        chki(k, "rst_out_valid", int'(ov[k]), 0);
        chki(k, "rst_busy", int'(bsy[k]), 0);
        chk (k, "rst_out_state", ost[k], '0);
        chki(k, "rst_out_inverse", int'(oinv[k]), 0);
        @(posedge clk); #1;

        // Known-answer forward block, then the inverse round trip.
        send(k, 128'h00112233445566778899aabbccddeeff, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816, dummy);
        chki(k, "run_busy", int'(bsy[k]), 1);
        chki(k, "run_in_ready", int'(ir[k]), 0);
        chki(k, "run_out_valid", int'(ov[k]), 0);
        wait_idle(k);
        send(k, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 128'h00112233445566778899aabbccddeeff, dummy);
        wait_idle(k);

        // Backpressure: 10 cycles stalled in DONE with churning inputs, then exactly one transfer.
        ordy[k] = 1'b0;
        r = rnd();
        send_m(k, r, 1'b0, dummy);
        t = 0;
        while (!ov[k] && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!ov[k]) fail_now(k, "bp_out_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            iv[k] = 1'b1; ist[k] = rnd(); iinv[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        @(posedge clk); #1;
        iv[k] = 1'b0; ordy[k] = 1'b1;
        wait_idle(k);
        repeat (3) begin
            @(negedge clk);
            chki(k, "bp_single_transfer", int'(ov[k]), 0);
        end
        @(posedge clk); #1;

        // Back-to-back with alternating mode.
        r0 = rnd(); r1 = rnd(); r2 = rnd();
        send_m(k, r0, 1'b0, a0);
        send_m(k, r1, 1'b1, a1);
        send_m(k, r2, 1'b0, a2);
        chki(k, "b2b_gap1", int'(a1 - a0), beats_of(k) + 1);
        chki(k, "b2b_gap2", int'(a2 - a1), beats_of(k) + 1);
        wait_idle(k);

        // Reset mid-RUN (cnt = 2 where the block is long enough, else first RUN cycle).
        r = rnd();
        send_m(k, r, 1'b1, dummy);
        repeat ((beats_of(k) > 2) ? 2 : 0) begin
            @(posedge clk); #1;
        end
        rst_a[k] = 1'b1;
        q[k].delete(); seen[k] = 1'b0; held[k] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chki(k, "midrst_out_valid", int'(ov[k]), 0);
            chki(k, "midrst_busy", int'(bsy[k]), 0);
        end
        @(posedge clk); #1;
        rst_a[k] = 1'b0;
        @(negedge clk);
        chki(k, "midrst_in_ready", int'(ir[k]), 1);
        chki(k, "midrst_after_valid", int'(ov[k]), 0);
        @(posedge clk); #1;
        r = rnd();
        send_m(k, r, 1'b0, dummy);
        wait_idle(k);

        // Every byte value through both tables.
        for (int m = 0; m < 2; m++) begin
            for (int b = 0; b < 16; b++) begin
                for (int i = 0; i < SB; i++) blk[8*(SB-1-i) +: 8] = 8'(b * 16 + i);
                send_m(k, blk, 1'(m), dummy);
            end
        end
        wait_idle(k);

        // Random blocks with occasional idle gaps.
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
            send_m(k, rnd(), 1'($urandom_range(0, 1)), dummy);
        end
        wait_idle(k);

        n_done++;
    endtask

    initial begin
        for (int x = 0; x < 256; x++) sb[x] = sbox_calc(8'(x));
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
        for (int k = 0; k < NI; k++) begin
            seen[k] = 1'b0; held[k] = 1'b0; prev_st[k] = '0; prev_inv[k] = 1'b0;
        end
        fork
            begin
                while (n_done < NI) begin
                    @(negedge clk);
                    for (int k = 0; k < NI; k++) mon_step(k);
                end
            end
            run_inst(0);
            run_inst(1);
            run_inst(2);
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
